ocdve_apb_reg_slave: RTL and testbench
======================================

Name: ocdve_apb_reg_slave

Overview:
- APB3 completer that terminates an APB bus and exposes a bank of NUM_REGS word registers to design logic.
- Sits directly downstream of the APB interface bundle and drives its completer-side signals: pready, prdata and pslverr.
- Registers are read-write or read-only, selected by RO_MASK. Read-only registers return live hardware inputs.
- Wait-state insertion is configurable, so requester-side VIP can be stressed with stretched transfers.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, register and data bus width.
- NUM_REGS, 16, number of word registers; must be a power of two, minimum 2.
- WAIT_STATES, 0, access-phase cycles with pready low before completion; range 0..15.
- RO_MASK, 0, NUM_REGS bits; bit i set makes register i read-only.
- RESET_VAL, 0, DATA_WIDTH reset value of every read-write register.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- paddr  in  ADDR_WIDTH  byte address.
- psel  in  1  select.
- penable  in  1  access-phase flag.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer completion.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1.
- pslverr  out  1  error response; valid only while pready=1.
- regs_q  out  NUM_REGS*DATA_WIDTH  read-write register contents, flattened; register i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- ro_in  in  NUM_REGS*DATA_WIDTH  values returned for read-only indices; slices of read-write indices are ignored.
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit i, on each successful write to register i.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset. All outputs are registered.
- Reset values:
  - pready=0, prdata=0, pslverr=0, wr_pulse=0.
  - Every read-write register = RESET_VAL; FSM = IDLE; wait counter = 0.
- FSM states: IDLE and ACCESS.
  - IDLE: a setup cycle T (psel=1, penable=0) captures paddr, pwrite and pwdata, loads cnt=WAIT_STATES and moves to ACCESS.
  - ACCESS: while cnt>0 and psel=1, penable=1, cnt decrements and pready stays 0. pready=1 in cycle T+1+WAIT_STATES, the completion cycle. Next state is IDLE.
- Zero-wait case: pready=1 in cycle T+1, the first access cycle.
- Decode (at setup): idx = paddr[log2(NUM_REGS)+1:2].
  - err_addr = (paddr[1:0]!=0) or (paddr >= NUM_REGS*4).
  - err_ro = pwrite and RO_MASK[idx].
- Write, no error:
  - Register idx takes the captured pwdata at the clock edge ending the completion cycle.
  - Both regs_q and wr_pulse[idx]=1 are visible in cycle T+2+WAIT_STATES; wr_pulse is high for exactly one cycle.
- Read, no error: in the completion cycle, prdata = regs_q[idx] for read-write indices, or the ro_in[idx] slice sampled at the end of cycle T+WAIT_STATES for read-only indices.
- Error (err_addr or err_ro):
  - Completion cycle shows pslverr=1 and prdata=0.
  - No register or wr_pulse change.
  - Latency is identical to a good transfer.
- Outside the completion cycle: pready=0, prdata=0, pslverr=0.
- Back-to-back: a new setup cycle is accepted in the cycle immediately after completion (IDLE at that point).
- Protocol violation: if psel or penable is 0 during ACCESS before completion, the transfer is aborted. FSM returns to IDLE, no write occurs, pready stays 0. That same cycle is re-evaluated as a setup cycle if psel=1, penable=0.
- psel=1 with penable=1 in IDLE (no preceding setup) is ignored.
- Reset has priority over everything:
  - Asserted mid-transfer, the transfer is discarded, outputs return to reset values the next cycle, and any pending write is lost.
  - A completion cycle coinciding with reset commits nothing.
- prdata and pwdata are full-word only; there is no pstrb and no pprot.

Test Plan:
- Reset, then read all indices (WAIT_STATES=0) -> each read has pready=1 at T+1, prdata=RESET_VAL, pslverr=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 -> regs_q[2]=0xDEADBEEF at T+2, wr_pulse=0b100 for one cycle, read returns 0xDEADBEEF.
- WAIT_STATES=3, write 0x1234 to 0x04 -> pready low for cycles T+1..T+3, high at T+4, register updates at T+5.
- RO_MASK=0x1, ro_in[0]=0xCAFE0001: read 0x00 -> 0xCAFE0001; write 0x00 -> pslverr=1, wr_pulse=0.
- Errors on 0x03 (unaligned) and 0x40 (out of range, NUM_REGS=16), read and write -> pslverr=1, prdata=0, no register change.
- Reset asserted at T+2 of a WAIT_STATES=3 write -> no register update, pready=0 from T+3; a following back-to-back transfer completes normally.

Source files
------------

// File: rtl/ocdve_apb_reg_slave_if.sv
// APB3 bus bundle between a requester and the register-bank completer.
interface ocdve_apb_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/ocdve_apb_reg_slave.sv
// APB3 completer fronting a bank of word registers, with read-only live inputs
// and a configurable number of wait states.
//   state    | meaning
//   S_IDLE   | waiting for a setup cycle (psel=1, penable=0)
//   S_ACCESS | access phase; pready_q=1 marks the completion cycle
module ocdve_apb_reg_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    ocdve_apb_reg_slave_if.slave           apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int         IDX_W   = $clog2(NUM_REGS);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [DATA_WIDTH-1:0] regs_mem_q [NUM_REGS];
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  setup_d;
    logic                  access_d;
    logic                  start_d;
    logic [IDX_W-1:0]      live_idx_d;
    logic                  live_err_d;
    logic [IDX_W-1:0]      sel_idx_d;
    logic                  sel_err_d;
    logic                  sel_write_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    // An aborted access phase re-evaluates its cycle as a possible setup cycle.
    always_comb begin
        setup_d     = apb.psel && !apb.penable;
        access_d    = apb.psel && apb.penable;
        start_d     = setup_d && ((state_q == S_IDLE) || !pready_q);
        live_idx_d  = apb.paddr[IDX_W+1:2];
        live_err_d  = (apb.paddr[1:0] != 2'b00)
                    || (apb.paddr[ADDR_WIDTH-1:IDX_W+2] != '0)
                    || (apb.pwrite && RO_MASK[live_idx_d]);
        sel_idx_d   = start_d ? live_idx_d : idx_q;
        sel_err_d   = start_d ? live_err_d : err_q;
        sel_write_d = start_d ? apb.pwrite : write_q;
        rdata_d     = '0;
        if (!sel_err_d && !sel_write_d) begin
            rdata_d = RO_MASK[sel_idx_d] ? ro_in[int'(sel_idx_d)*DATA_WIDTH +: DATA_WIDTH]
                                         : regs_mem_q[sel_idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_mem_q[i] <= RESET_VAL;
        end else begin
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            if (start_d) begin
                state_q <= S_ACCESS;
                cnt_q   <= WS_INIT;
                idx_q   <= live_idx_d;
                write_q <= apb.pwrite;
                err_q   <= live_err_d;
                wdata_q <= apb.pwdata;
                if (WAIT_STATES == 0) begin
                    pready_q  <= 1'b1;
                    pslverr_q <= live_err_d;
                    prdata_q  <= rdata_d;
                end
            end else if (state_q == S_ACCESS) begin
                if (pready_q) begin
                    state_q <= S_IDLE;
                    if (write_q && !err_q) begin
                        regs_mem_q[idx_q] <= wdata_q;
                        wr_pulse_q[idx_q] <= 1'b1;
                    end
                end else if (access_d) begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        prdata_q  <= rdata_d;
                    end
                end else begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_mem_q[g];
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign wr_pulse    = wr_pulse_q;
endmodule

// File: tb/tb_ocdve_apb_reg_slave.sv
// Bench for the APB register slave: a zero-wait and a three-wait instance share
// one requester; a timeline model predicts every output cycle by cycle.
module tb_ocdve_apb_reg_slave;
    localparam logic [15:0] RO = 16'h0001;

    logic         clk;
    logic         reset;
    logic [31:0]  paddr;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [511:0] ro_in;
    logic [511:0] regs0, regs1;
    logic [15:0]  wr0, wr1;

    ocdve_apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    ocdve_apb_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();

    assign if0.paddr = paddr;  assign if1.paddr = paddr;
    assign if0.psel = psel;    assign if1.psel = psel;
    assign if0.penable = penable; assign if1.penable = penable;
    assign if0.pwrite = pwrite;   assign if1.pwrite = pwrite;
    assign if0.pwdata = pwdata;   assign if1.pwdata = pwdata;

    ocdve_apb_reg_slave #(.WAIT_STATES(0), .RO_MASK(RO), .RESET_VAL(32'h0000_0000)) u0 (
        .clk(clk), .reset(reset), .apb(if0), .regs_q(regs0), .ro_in(ro_in), .wr_pulse(wr0));
    ocdve_apb_reg_slave #(.WAIT_STATES(3), .RO_MASK(RO), .RESET_VAL(32'hA5A5_0000)) u1 (
        .clk(clk), .reset(reset), .apb(if1), .regs_q(regs1), .ro_in(ro_in), .wr_pulse(wr1));

    logic         act_pready [2];
    logic         act_pslverr [2];
    logic [31:0]  act_prdata [2];
    logic [15:0]  act_wr [2];
    logic [511:0] act_regs [2];
    assign act_pready[0] = if0.pready;   assign act_pready[1] = if1.pready;
    assign act_pslverr[0] = if0.pslverr; assign act_pslverr[1] = if1.pslverr;
    assign act_prdata[0] = if0.prdata;   assign act_prdata[1] = if1.prdata;
    assign act_wr[0] = wr0;    assign act_wr[1] = wr1;
    assign act_regs[0] = regs0; assign act_regs[1] = regs1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a transfer set up in cycle T completes in cycle T+1+WS unless an
    // intervening cycle lacks psel&penable; the write lands at the end of completion.
    int          cyc = 0;
    bit          model_live = 0;
    bit          m_busy [2];
    int          m_t [2];
    int          m_idx [2];
    bit          m_write [2];
    bit          m_err [2];
    logic [31:0] m_data [2];
    logic [31:0] m_regs [2][16];
    bit          exp_pready [2];
    bit          exp_pslverr [2];
    logic [31:0] exp_prdata [2];
    logic [15:0] exp_wr [2];

    function automatic void model_step(int d);
        bit done_now;
        int ws;
        ws = (d == 0) ? 0 : 3;
        exp_pready[d] = 0; exp_pslverr[d] = 0; exp_prdata[d] = '0; exp_wr[d] = '0;
        if (reset) begin
            m_busy[d] = 0;
            for (int i = 0; i < 16; i++) m_regs[d][i] = (d == 0) ? 32'h0 : 32'hA5A5_0000;
            return;
        end
        done_now = m_busy[d] && (cyc == m_t[d] + 1 + ws);
        if (done_now) begin
            if (m_write[d] && !m_err[d]) begin
                m_regs[d][m_idx[d]] = m_data[d];
                exp_wr[d][m_idx[d]] = 1'b1;
            end
            m_busy[d] = 0;
        end else if (m_busy[d] && !(psel && penable)) begin
            m_busy[d] = 0;
        end
        if (!m_busy[d] && !done_now && psel && !penable) begin
            m_busy[d]  = 1;
            m_t[d]     = cyc;
            m_idx[d]   = int'(paddr[5:2]);
            m_write[d] = pwrite;
            m_data[d]  = pwdata;
            m_err[d]   = (paddr % 4 != 0) || (paddr >= 64) || (pwrite && RO[m_idx[d]]);
        end
        if (m_busy[d] && cyc == m_t[d] + ws) begin
            exp_pready[d]  = 1;
            exp_pslverr[d] = m_err[d];
            if (!m_err[d] && !m_write[d])
                exp_prdata[d] = RO[m_idx[d]] ? ro_in[m_idx[d]*32 +: 32] : m_regs[d][m_idx[d]];
        end
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) model_step(d);
        model_live = 1;
    end

    task automatic cmp(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            for (int d = 0; d < 2; d++) begin
                cmp("pready", d, 32'(act_pready[d]), 32'(exp_pready[d]));
                cmp("pslverr", d, 32'(act_pslverr[d]), 32'(exp_pslverr[d]));
                cmp("prdata", d, act_prdata[d], exp_prdata[d]);
                cmp("wr_pulse", d, 32'(act_wr[d]), 32'(exp_wr[d]));
                for (int i = 0; i < 16; i++)
                    cmp($sformatf("regs_q[%0d]", i), d, act_regs[d][i*32 +: 32], m_regs[d][i]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [31:0] r_data [2];
    bit          r_err [2];
    int          r_lat [2];
    logic [15:0] r_wr0;

    // Setup plus four access cycles, enough for either instance to complete.
    task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] v);
        @(negedge clk);
        paddr = a; pwrite = w; pwdata = v; psel = 1'b1; penable = 1'b0;
        for (int d = 0; d < 2; d++) begin r_lat[d] = 0; r_data[d] = '0; r_err[d] = 0; end
        r_wr0 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            penable = 1'b1;
            if (k == 1) r_wr0 = act_wr[0];
            for (int d = 0; d < 2; d++) begin
                if (act_pready[d] && r_lat[d] == 0) begin
                    r_lat[d] = k + 1; r_data[d] = act_prdata[d]; r_err[d] = act_pslverr[d];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        for (int i = 0; i < 16; i++) ro_in[i*32 +: 32] = 32'h1111_0000 + 32'(i);
        ro_in[31:0] = 32'hCAFE_0001;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 16; i++) begin
            xfer(32'(i * 4), 1'b0, 32'h0);
            if (i == 0) begin
                chk("lat_ws0", 32'(r_lat[0]), 32'd1);
                chk("lat_ws3", 32'(r_lat[1]), 32'd4);
                chk("ro_read0", r_data[0], 32'hCAFE_0001);
                chk("ro_read1", r_data[1], 32'hCAFE_0001);
            end
            if (i == 5) begin
                chk("rst_read0", r_data[0], 32'h0000_0000);
                chk("rst_read1", r_data[1], 32'hA5A5_0000);
            end
        end

        xfer(32'h08, 1'b1, 32'hDEAD_BEEF);
        chk("wr_pulse_t2", 32'(r_wr0), 32'h0000_0004);
        chk("wr_err", 32'(r_err[1]), 32'd0);
        xfer(32'h08, 1'b0, 32'h0);
        chk("rd08_0", r_data[0], 32'hDEAD_BEEF);
        chk("rd08_1", r_data[1], 32'hDEAD_BEEF);

        xfer(32'h04, 1'b1, 32'h0000_1234);
        chk("lat_wr_ws3", 32'(r_lat[1]), 32'd4);
        idle(1);
        chk("reg1_after", regs1[63:32], 32'h0000_1234);
        xfer(32'h04, 1'b0, 32'h0);
        chk("rd04_1", r_data[1], 32'h0000_1234);

        xfer(32'h00, 1'b1, 32'h5555_5555);
        chk("ro_wr_err", 32'(r_err[1]), 32'd1);
        chk("ro_wr_pulse", 32'(r_wr0), 32'h0);
        xfer(32'h03, 1'b0, 32'h0);
        chk("unal_rd_err", 32'(r_err[0]), 32'd1);
        chk("unal_rd_data", r_data[0], 32'h0);
        xfer(32'h03, 1'b1, 32'h9999_9999);
        chk("unal_wr_err", 32'(r_err[1]), 32'd1);
        xfer(32'h40, 1'b0, 32'h0);
        chk("oor_rd_err", 32'(r_err[1]), 32'd1);
        chk("oor_rd_data", r_data[1], 32'h0);
        xfer(32'h40, 1'b1, 32'h9999_9999);
        chk("oor_wr_err", 32'(r_err[0]), 32'd1);

        // Drop penable after one access cycle: the three-wait instance aborts.
        @(negedge clk);
        paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h7777_8888; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        xfer(32'h0C, 1'b0, 32'h0);
        chk("abort_rd0", r_data[0], 32'h7777_8888);
        chk("abort_rd1", r_data[1], 32'hA5A5_0000);
        idle(1);

        // Reset in the second access cycle of a write.
        @(negedge clk);
        paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h5555_AAAA; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("rst_pready", 32'(act_pready[1]), 32'd0);
        xfer(32'h10, 1'b0, 32'h0);
        chk("post_rst_rd0", r_data[0], 32'h0000_0000);
        chk("post_rst_rd1", r_data[1], 32'hA5A5_0000);
        xfer(32'h3C, 1'b1, 32'h0F0F_0F0F);
        xfer(32'h3C, 1'b0, 32'h0);
        chk("final_rd0", r_data[0], 32'h0F0F_0F0F);
        chk("final_rd1", r_data[1], 32'h0F0F_0F0F);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
